// File: rtl/regfile_scoreboard.sv
// Register file with write-back bypass plus per-register in-flight write counters for RAW hazard detection.
// Reads and busy flags are combinational; writes and counter updates land on the clock edge; flags are registered pulses.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              stall,
   input  logic              flush,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic              reg_write_to_file,
   input  logic [ADDR_W-1:0] reg_write_addr,
   input  logic [DATA_W-1:0] reg_write_data,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic              sb_overflow,
   output logic              sb_underflow
);

   localparam int NREG = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [CNT_W-1:0]  cnt_q  [NREG];
   logic [CNT_W-1:0]  cnt_d  [NREG];
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              iss, ret;

   assign iss = issue_valid & ~stall & (issue_addr != '0);
   assign ret = reg_write_to_file & (reg_write_addr != '0);

   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      if (ret) regs_d[reg_write_addr] = reg_write_data;
      if (flush) begin
         for (int i = 0; i < NREG; i++) cnt_d[i] = '0;
      end else if (!(iss && ret && issue_addr == reg_write_addr)) begin
         // Issue and retire to the same register cancel out; otherwise each applies on its own.
         if (iss) begin
            if (cnt_q[issue_addr] == CNT_MAX) ovf_d = 1'b1;
            else cnt_d[issue_addr] = cnt_q[issue_addr] + CNT_ONE;
         end
         if (ret) begin
            if (cnt_q[reg_write_addr] == '0) unf_d = 1'b1;
            else cnt_d[reg_write_addr] = cnt_q[reg_write_addr] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   // A register whose last outstanding write is retiring this cycle is served by the bypass, so not busy.
   always_comb begin
      rs_data = '0;
      rt_data = '0;
      if (rs_addr != '0) rs_data = (ret && reg_write_addr == rs_addr) ? reg_write_data : regs_q[rs_addr];
      if (rt_addr != '0) rt_data = (ret && reg_write_addr == rt_addr) ? reg_write_data : regs_q[rt_addr];
      rs_busy = (rs_addr != '0) && (cnt_q[rs_addr] != '0)
                && !(ret && reg_write_addr == rs_addr && cnt_q[rs_addr] == CNT_ONE);
      rt_busy = (rt_addr != '0) && (cnt_q[rt_addr] != '0)
                && !(ret && reg_write_addr == rt_addr && cnt_q[rt_addr] == CNT_ONE);
   end

   assign sb_overflow  = ovf_q;
   assign sb_underflow = unf_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against a plain-array reference model.
module tb_regfile_scoreboard;

   localparam int MAXCNT = 3;

   logic        clk;
   logic        rstn;
   logic        stall, flush, issue_valid, reg_write_to_file;
   logic [4:0]  issue_addr, reg_write_addr, rs_addr, rt_addr;
   logic [31:0] reg_write_data;
   logic [31:0] rs_data, rt_data;
   logic        rs_busy, rt_busy, sb_overflow, sb_underflow;

   int          cmp_cnt = 0;
   int          err_cnt = 0;

   logic [31:0] m_reg [32];
   int          m_pending [32];
   logic        m_ovf, m_unf;

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
      .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .reg_write_to_file(reg_write_to_file), .reg_write_addr(reg_write_addr),
      .reg_write_data(reg_write_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data), .rt_data(rt_data), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .sb_overflow(sb_overflow), .sb_underflow(sb_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (reg_write_to_file && reg_write_addr == a) return reg_write_data;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0 || m_pending[a] == 0) return 1'b0;
      if (reg_write_to_file && reg_write_addr == a && m_pending[a] == 1) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i] = 32'h0;
         m_pending[i] = 0;
      end
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_edge();
      bit iss, ret;
      iss = issue_valid && !stall && issue_addr != 0;
      ret = reg_write_to_file && reg_write_addr != 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (ret) m_reg[reg_write_addr] = reg_write_data;
      if (flush) begin
         for (int i = 0; i < 32; i++) m_pending[i] = 0;
      end else if (!(iss && ret && issue_addr == reg_write_addr)) begin
         if (iss) begin
            if (m_pending[issue_addr] >= MAXCNT) m_ovf = 1'b1;
            else m_pending[issue_addr] = m_pending[issue_addr] + 1;
         end
         if (ret) begin
            if (m_pending[reg_write_addr] <= 0) m_unf = 1'b1;
            else m_pending[reg_write_addr] = m_pending[reg_write_addr] - 1;
         end
      end
   endtask

   task automatic check_all();
      check("rs_data", rs_data, exp_read(rs_addr));
      check("rt_data", rt_data, exp_read(rt_addr));
      check("rs_busy", {31'b0, rs_busy}, {31'b0, exp_busy(rs_addr)});
      check("rt_busy", {31'b0, rt_busy}, {31'b0, exp_busy(rt_addr)});
      check("sb_overflow", {31'b0, sb_overflow}, {31'b0, m_ovf});
      check("sb_underflow", {31'b0, sb_underflow}, {31'b0, m_unf});
   endtask

   task automatic cycle(input logic iv, input logic [4:0] ia, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic st, input logic fl,
                        input logic [4:0] ra, input logic [4:0] rb);
      @(negedge clk);
      issue_valid = iv; issue_addr = ia;
      reg_write_to_file = we; reg_write_addr = wa; reg_write_data = wd;
      stall = st; flush = fl; rs_addr = ra; rt_addr = rb;
      #1;
      check_all();
      @(posedge clk);
      model_edge();
   endtask

   task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
      cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, ra, rb);
   endtask

   task automatic reset_mid_run(input logic [4:0] ra);
      @(negedge clk);
      issue_valid = 1'b0; reg_write_to_file = 1'b0; stall = 1'b0; flush = 1'b0;
      rs_addr = ra; rt_addr = ra;
      #1;
      check_all();
      rstn = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      rstn = 1'b0;
      issue_valid = 1'b0; issue_addr = '0; reg_write_to_file = 1'b0; reg_write_addr = '0;
      reg_write_data = '0; stall = 1'b0; flush = 1'b0; rs_addr = 5'd1; rt_addr = 5'd2;
      model_reset();
      #3;
      check_all();
      @(negedge clk);
      rstn = 1'b1;

      // Asynchronous reset with r5 written and pending
      cycle(1'b1, 5'd5, 1'b1, 5'd5, 32'hDEAD, 1'b0, 1'b0, 5'd5, 5'd0);
      cycle(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd5, 5'd5);
      reset_mid_run(5'd5);
      idle(5'd5, 5'd5);

      // r0 is never written and never busy
      cycle(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 5'd0);
      idle(5'd0, 5'd0);
      idle(5'd0, 5'd0);

      // Same-cycle bypass on both ports, then from the array
      cycle(1'b0, 5'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 1'b0, 5'd7, 5'd7);
      idle(5'd7, 5'd7);

      // Saturation at three outstanding writes, then drain
      for (int i = 0; i < 4; i++) cycle(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd3);
      idle(5'd3, 5'd3);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 5'd0, 1'b1, 5'd3, 32'hA000 + i, 1'b0, 1'b0, 5'd3, 5'd3);
      idle(5'd3, 5'd3);

      // Simultaneous issue and retire on one register
      cycle(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd9, 5'd9);
      cycle(1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 5'd9, 5'd9);
      idle(5'd9, 5'd9);
      cycle(1'b0, 5'd0, 1'b1, 5'd9, 32'h9A, 1'b0, 1'b0, 5'd9, 5'd9);
      idle(5'd9, 5'd9);

      // Stall blocks issue, flush clears, retire at zero underflows
      cycle(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd4, 5'd4);
      cycle(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd4, 5'd4);
      cycle(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd4, 5'd4);
      cycle(1'b0, 5'd0, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 5'd4, 5'd6);
      idle(5'd4, 5'd6);
      cycle(1'b0, 5'd0, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 5'd4, 5'd4);
      idle(5'd4, 5'd4);

      // Random traffic over a narrow address range to force collisions
      for (int n = 0; n < 800; n++) begin
         if (n == 400) reset_mid_run(5'($urandom_range(0, 7)));
         cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle(5'd1, 5'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
